// File: rtl/inst_rom_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// inst_rom_arbiter_pkg
//
// Shared definitions for the instruction-ROM arbiter slice: the round-robin
// priority encoding, requester slot indices, ROM enable levels and the
// alignment helper.  Imported by inst_rom_arbiter and its arbiter core.
// ---------------------------------------------------------------------------
package inst_rom_arbiter_pkg;

  // Which requester wins the next contested cycle
  typedef enum logic {
    RomPrioIf = 1'b0,
    RomPrioLs = 1'b1
  } romPrio_t;

  // Slot of each requester inside the two-bit req/gnt vectors
  localparam int unsigned ReqIf = 0;
  localparam int unsigned ReqLs = 1;

  // ROM chip-enable levels
  localparam logic ReadEnable  = 1'b1;
  localparam logic ReadDisable = 1'b0;

  // A word access is misaligned when either of the two byte-offset bits is set
  function automatic logic isMisaligned(input logic [1:0] lowBits);
    return |lowBits;
  endfunction

endpackage

// File: rtl/inst_rom_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// inst_rom_arbiter_rr_arb2
//
// Two-input round-robin arbiter.  Grants are combinational from the request
// vector and the priority pointer; the pointer flips only when both inputs
// request in the same cycle, so a lone requester never disturbs fairness.
// Written generically so the data-RAM port can reuse it.
//
// Ports:
//   clk    in   clock, pointer updates on the rising edge
//   rst    in   asynchronous active-high reset, pointer returns to IF
//   req_i  in   [1:0] request vector (bit ReqIf, bit ReqLs)
//   gnt_o  out  [1:0] one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module inst_rom_arbiter_rr_arb2
  import inst_rom_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  romPrio_t r_prio;
  logic     w_contested;

  assign w_contested = req_i[ReqIf] & req_i[ReqLs];

  // Pick the winner: a lone requester always wins, and when both request
  // the side named by the pointer wins.  The LS branch is reached either
  // because IF is idle or because the pointer favours LS.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[ReqIf] && (!req_i[ReqLs] || (r_prio == RomPrioIf))) begin
      gnt_o[ReqIf] = 1'b1;
    end else if (req_i[ReqLs]) begin
      gnt_o[ReqLs] = 1'b1;
    end
  end

  // Hand priority to the loser after every contested grant; uncontested
  // and idle cycles leave the pointer alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= RomPrioIf;
    end else if (w_contested) begin
      r_prio <= (r_prio == RomPrioIf) ? RomPrioLs : RomPrioIf;
    end
  end

endmodule

// File: rtl/inst_rom_arbiter.sv
// ---------------------------------------------------------------------------
// inst_rom_arbiter
//
// Shares the single combinational instruction ROM between the instruction
// fetch stage (IF) and the load/store unit (LS).  Each cycle at most one
// requester is granted; the grant drives the ROM address and chip enable in
// the same cycle and the ROM word is captured into a one-cycle-latency
// response for the winner.  Misaligned addresses return an error response
// without enabling the ROM, and a pipeline flush blocks new IF grants and
// hides an IF response that is being presented.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   if_req_i / if_addr_i         IF read request and byte address
//   if_gnt_o                     IF accepted this cycle (combinational)
//   if_rvalid_o/if_rdata_o/if_err_o  IF response, one cycle after grant
//   ls_req_i / ls_addr_i         LS read request and byte address
//   ls_gnt_o                     LS accepted this cycle (combinational)
//   ls_rvalid_o/ls_rdata_o/ls_err_o  LS response, one cycle after grant
//   flush_i                      pipeline flush, affects IF only
//   rom_ce_o / rom_addr_o        ROM chip enable and byte address
//   rom_inst_i                   ROM word, combinational from rom_addr_o
// ---------------------------------------------------------------------------
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_err_o,
  input  logic              flush_i,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i
);

  logic [1:0]        w_arbReq;
  logic [1:0]        w_gnt;
  logic              w_anyGnt;
  logic [ADDR_W-1:0] w_winAddr;
  logic              w_misaligned;
  logic [DATA_W-1:0] w_rspWord;

  logic [ADDR_W-1:0] r_romAddr;
  logic              r_ifRvalid;
  logic [DATA_W-1:0] r_ifRdata;
  logic              r_ifErr;
  logic              r_lsRvalid;
  logic [DATA_W-1:0] r_lsRdata;
  logic              r_lsErr;

  // Requests seen by the arbiter.  A flush removes IF from the competition
  // entirely, so a flush during contention is an uncontested LS grant and
  // the pointer stays put.  Masking with rst keeps every grant low while the
  // block is held in reset.
  assign w_arbReq[ReqIf] = if_req_i & ~flush_i & ~rst;
  assign w_arbReq[ReqLs] = ls_req_i & ~rst;

  inst_rom_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (w_arbReq),
    .gnt_o (w_gnt)
  );

  assign if_gnt_o = w_gnt[ReqIf];
  assign ls_gnt_o = w_gnt[ReqLs];
  assign w_anyGnt = |w_gnt;

  // The winner's address goes to the ROM; misaligned accesses still present
  // their address but leave the ROM disabled and answer with a zero word.
  assign w_winAddr    = w_gnt[ReqLs] ? ls_addr_i : if_addr_i;
  assign w_misaligned = isMisaligned(w_winAddr[1:0]);
  assign w_rspWord    = w_misaligned ? '0 : rom_inst_i;

  assign rom_ce_o   = (w_anyGnt && !w_misaligned) ? ReadEnable : ReadDisable;
  assign rom_addr_o = w_anyGnt ? w_winAddr : r_romAddr;

  // Remember the last address driven so that idle cycles keep the ROM
  // address bus steady instead of following whatever the requesters drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_romAddr <= '0;
    end else if (w_anyGnt) begin
      r_romAddr <= w_winAddr;
    end
  end

  // IF response register: rvalid and err are single-cycle pulses following
  // a grant; rdata only changes on an IF grant so it holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifRvalid <= 1'b0;
      r_ifRdata  <= '0;
      r_ifErr    <= 1'b0;
    end else begin
      r_ifRvalid <= w_gnt[ReqIf];
      r_ifErr    <= w_gnt[ReqIf] & w_misaligned;
      if (w_gnt[ReqIf]) begin
        r_ifRdata <= w_rspWord;
      end
    end
  end

  // LS response register, same shape as the IF one; flush never touches it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lsRvalid <= 1'b0;
      r_lsRdata  <= '0;
      r_lsErr    <= 1'b0;
    end else begin
      r_lsRvalid <= w_gnt[ReqLs];
      r_lsErr    <= w_gnt[ReqLs] & w_misaligned;
      if (w_gnt[ReqLs]) begin
        r_lsRdata <= w_rspWord;
      end
    end
  end

  // A flush in the cycle an IF response is presented kills that response,
  // since the instruction belongs to the path being discarded.
  assign if_rvalid_o = r_ifRvalid & ~flush_i;
  assign if_err_o    = r_ifErr & ~flush_i;
  assign if_rdata_o  = r_ifRdata;

  assign ls_rvalid_o = r_lsRvalid;
  assign ls_err_o    = r_lsErr;
  assign ls_rdata_o  = r_lsRdata;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inst_rom_arbiter
//
// Table-driven bench for inst_rom_arbiter.  Each table row is one clock
// cycle: the inputs driven in that cycle and the outputs expected while they
// are applied (responses belong to the previous cycle's grant).  The async
// reset corner is exercised by a hand-written sequence after the table.
// ---------------------------------------------------------------------------
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;
  logic        ls_req_i;
  logic [31:0] ls_addr_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        ls_err_o;
  logic        flush_i;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;

  int checks;
  int errors;

  typedef struct {
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        lsReq;
    logic [31:0] lsAddr;
    logic        flush;
    logic        expIfGnt;
    logic        expLsGnt;
    logic        expRomCe;
    logic [31:0] expRomAddr;
    logic        expIfRvalid;
    logic [31:0] expIfRdata;
    logic        expIfErr;
    logic        expLsRvalid;
    logic [31:0] expLsRdata;
    logic        expLsErr;
  } vec_t;

  vec_t vecs[$];

  // ROM contents: word k holds a distinct, easily recognised pattern
  function automatic logic [31:0] romWord(input logic [7:0] k);
    return {16'hC0DE, 8'hA5 ^ k, k};
  endfunction

  // Combinational instruction ROM model driven by the DUT address
  assign rom_inst_i = romWord(rom_addr_o[9:2]);

  inst_rom_arbiter #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .if_err_o    (if_err_o),
    .ls_req_i    (ls_req_i),
    .ls_addr_i   (ls_addr_i),
    .ls_gnt_o    (ls_gnt_o),
    .ls_rvalid_o (ls_rvalid_o),
    .ls_rdata_o  (ls_rdata_o),
    .ls_err_o    (ls_err_o),
    .flush_i     (flush_i),
    .rom_ce_o    (rom_ce_o),
    .rom_addr_o  (rom_addr_o),
    .rom_inst_i  (rom_inst_i)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic ifReq, input logic [31:0] ifAddr,
                        input logic lsReq, input logic [31:0] lsAddr,
                        input logic flush,
                        input logic eIfGnt, input logic eLsGnt,
                        input logic eRomCe, input logic [31:0] eRomAddr,
                        input logic eIfRv, input logic [31:0] eIfRd, input logic eIfErr,
                        input logic eLsRv, input logic [31:0] eLsRd, input logic eLsErr);
    vec_t v;
    v.ifReq = ifReq;      v.ifAddr = ifAddr;
    v.lsReq = lsReq;      v.lsAddr = lsAddr;
    v.flush = flush;
    v.expIfGnt = eIfGnt;  v.expLsGnt = eLsGnt;
    v.expRomCe = eRomCe;  v.expRomAddr = eRomAddr;
    v.expIfRvalid = eIfRv; v.expIfRdata = eIfRd; v.expIfErr = eIfErr;
    v.expLsRvalid = eLsRv; v.expLsRdata = eLsRd; v.expLsErr = eLsErr;
    vecs.push_back(v);
  endtask

  task automatic checkValue(input string name, input int cyc,
                            input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req_i  = v.ifReq;
    if_addr_i = v.ifAddr;
    ls_req_i  = v.lsReq;
    ls_addr_i = v.lsAddr;
    flush_i   = v.flush;
  endtask

  task automatic checkOutput(input vec_t v, input int cyc);
    checkValue("if_gnt",    cyc, {31'b0, if_gnt_o},    {31'b0, v.expIfGnt});
    checkValue("ls_gnt",    cyc, {31'b0, ls_gnt_o},    {31'b0, v.expLsGnt});
    checkValue("rom_ce",    cyc, {31'b0, rom_ce_o},    {31'b0, v.expRomCe});
    checkValue("rom_addr",  cyc, rom_addr_o,           v.expRomAddr);
    checkValue("if_rvalid", cyc, {31'b0, if_rvalid_o}, {31'b0, v.expIfRvalid});
    checkValue("if_rdata",  cyc, if_rdata_o,           v.expIfRdata);
    checkValue("if_err",    cyc, {31'b0, if_err_o},    {31'b0, v.expIfErr});
    checkValue("ls_rvalid", cyc, {31'b0, ls_rvalid_o}, {31'b0, v.expLsRvalid});
    checkValue("ls_rdata",  cyc, ls_rdata_o,           v.expLsRdata);
    checkValue("ls_err",    cyc, {31'b0, ls_err_o},    {31'b0, v.expLsErr});
  endtask

  initial begin
    logic [31:0] r0, r1, r2, r4, r8, r9, r10, r16;
    checks = 0;
    errors = 0;
    r0  = romWord(8'd0);
    r1  = romWord(8'd1);
    r2  = romWord(8'd2);
    r4  = romWord(8'd4);
    r8  = romWord(8'd8);
    r9  = romWord(8'd9);
    r10 = romWord(8'd10);
    r16 = romWord(8'd16);

    //     ifReq ifAddr     lsReq lsAddr     fl | ifG lsG ce romAddr    | ifRv ifRd ifE | lsRv lsRd lsE
    // IF-only stream
    addVec(1, 32'h00, 0, 32'h00, 0,  1, 0, 1, 32'h00,  0, 32'h0, 0,  0, 32'h0, 0);
    addVec(1, 32'h04, 0, 32'h00, 0,  1, 0, 1, 32'h04,  1, r0,    0,  0, 32'h0, 0);
    addVec(1, 32'h08, 0, 32'h00, 0,  1, 0, 1, 32'h08,  1, r1,    0,  0, 32'h0, 0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h08,  1, r2,    0,  0, 32'h0, 0);
    // Contention: grants alternate IF, LS, IF, LS
    addVec(1, 32'h10, 1, 32'h20, 0,  1, 0, 1, 32'h10,  0, r2,    0,  0, 32'h0, 0);
    addVec(1, 32'h10, 1, 32'h20, 0,  0, 1, 1, 32'h20,  1, r4,    0,  0, 32'h0, 0);
    addVec(1, 32'h10, 1, 32'h20, 0,  1, 0, 1, 32'h10,  0, r4,    0,  1, r8,    0);
    addVec(1, 32'h10, 1, 32'h20, 0,  0, 1, 1, 32'h20,  1, r4,    0,  0, r8,    0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h20,  0, r4,    0,  1, r8,    0);
    // Misaligned LS
    addVec(0, 32'h00, 1, 32'h06, 0,  0, 1, 0, 32'h06,  0, r4,    0,  0, r8,    0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h06,  0, r4,    0,  1, 32'h0, 1);
    // Flush kills the IF response being presented
    addVec(1, 32'h40, 0, 32'h00, 0,  1, 0, 1, 32'h40,  0, r4,    0,  0, 32'h0, 0);
    addVec(0, 32'h00, 0, 32'h00, 1,  0, 0, 0, 32'h40,  0, r16,   0,  0, 32'h0, 0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h40,  0, r16,   0,  0, 32'h0, 0);
    // Flush during contention: LS wins, pointer stays on IF
    addVec(1, 32'h10, 1, 32'h24, 1,  0, 1, 1, 32'h24,  0, r16,   0,  0, 32'h0, 0);
    addVec(1, 32'h10, 1, 32'h24, 0,  1, 0, 1, 32'h10,  0, r16,   0,  1, r9,    0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h10,  1, r4,    0,  0, r9,    0);
    // Misaligned IF
    addVec(1, 32'h03, 0, 32'h00, 0,  1, 0, 0, 32'h03,  0, r4,    0,  0, r9,    0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h03,  1, 32'h0, 1,  0, r9,    0);
    // Flush blocks an IF grant in the same cycle
    addVec(1, 32'h08, 0, 32'h00, 1,  0, 0, 0, 32'h03,  0, 32'h0, 0,  0, r9,    0);
    // Idle for five cycles: pointer (now LS) must survive
    for (int i = 0; i < 5; i++) begin
      addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h03,  0, 32'h0, 0,  0, r9,    0);
    end
    addVec(1, 32'h10, 1, 32'h28, 0,  0, 1, 1, 32'h28,  0, 32'h0, 0,  0, r9,    0);
    addVec(0, 32'h00, 0, 32'h00, 0,  0, 0, 0, 32'h28,  0, 32'h0, 0,  1, r10,   0);

    // Reset state, with requests asserted to show grants stay low
    rst       = 1'b1;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0;
    ls_req_i  = 1'b1;
    ls_addr_i = 32'h0;
    flush_i   = 1'b0;
    @(negedge clk);
    checkValue("rst_if_gnt",    -1, {31'b0, if_gnt_o},    32'h0);
    checkValue("rst_ls_gnt",    -1, {31'b0, ls_gnt_o},    32'h0);
    checkValue("rst_rom_ce",    -1, {31'b0, rom_ce_o},    32'h0);
    checkValue("rst_rom_addr",  -1, rom_addr_o,           32'h0);
    checkValue("rst_if_rvalid", -1, {31'b0, if_rvalid_o}, 32'h0);
    checkValue("rst_ls_rvalid", -1, {31'b0, ls_rvalid_o}, 32'h0);
    checkValue("rst_if_rdata",  -1, if_rdata_o,           32'h0);
    checkValue("rst_ls_rdata",  -1, ls_rdata_o,           32'h0);
    checkValue("rst_if_err",    -1, {31'b0, if_err_o},    32'h0);
    checkValue("rst_ls_err",    -1, {31'b0, ls_err_o},    32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table: one row per clock cycle
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end

    // Async reset while an IF response is being presented.  Pointer is IF;
    // this contested grant moves it to LS, so only a reset brings it back.
    if_req_i  = 1'b1; if_addr_i = 32'h10;
    ls_req_i  = 1'b1; ls_addr_i = 32'h20;
    flush_i   = 1'b0;
    @(negedge clk);
    checkValue("pre_rst_if_gnt", 100, {31'b0, if_gnt_o}, 32'h1);
    @(posedge clk);
    #1;
    if_addr_i = 32'h04;
    ls_req_i  = 1'b0;
    #1;
    checkValue("pending_if_rvalid", 101, {31'b0, if_rvalid_o}, 32'h1);
    checkValue("pending_if_rdata",  101, if_rdata_o,           r4);
    rst = 1'b1;
    #1;
    checkValue("midrst_if_rvalid", 101, {31'b0, if_rvalid_o}, 32'h0);
    checkValue("midrst_if_rdata",  101, if_rdata_o,           32'h0);
    checkValue("midrst_ls_rdata",  101, ls_rdata_o,           32'h0);
    checkValue("midrst_if_gnt",    101, {31'b0, if_gnt_o},    32'h0);
    checkValue("midrst_rom_ce",    101, {31'b0, rom_ce_o},    32'h0);
    checkValue("midrst_rom_addr",  101, rom_addr_o,           32'h0);
    if_req_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkValue("postrst_if_rvalid", 102, {31'b0, if_rvalid_o}, 32'h0);
    checkValue("postrst_ls_rvalid", 102, {31'b0, ls_rvalid_o}, 32'h0);
    @(posedge clk);
    #1;
    if_req_i = 1'b1; if_addr_i = 32'h08;
    ls_req_i = 1'b1; ls_addr_i = 32'h20;
    @(negedge clk);
    checkValue("postrst_if_gnt", 103, {31'b0, if_gnt_o}, 32'h1);
    checkValue("postrst_ls_gnt", 103, {31'b0, ls_gnt_o}, 32'h0);
    @(posedge clk);
    #1;
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    @(negedge clk);
    checkValue("postrst_if_rvalid2", 104, {31'b0, if_rvalid_o}, 32'h1);
    checkValue("postrst_if_rdata2",  104, if_rdata_o,           r2);
    checkValue("postrst_ls_rvalid2", 104, {31'b0, ls_rvalid_o}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
